// File: rtl/digital_timer_pkg.sv
// digital_timer_pkg: FSM state encoding and default parameters shared by the timer controller
package digital_timer_pkg;
    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        RUN   = 2'd1,
        PAUSE = 2'd2,
        DONE  = 2'd3
    } state_t;
    localparam int          DEF_TICK_DIV  = 50_000_000;
    localparam logic [11:0] DEF_LIMIT_BCD = 12'h999;
endpackage

// File: rtl/timer_btn_cond.sv
// timer_btn_cond: synchronise a raw button, debounce it when DEBOUNCE_EN is defined, emit a one-cycle press pulse
module timer_btn_cond #(
    parameter int SYNC_STAGES = 2,
    parameter int DEB_CYCLES  = 1_000_000
) (
    input  logic clk,
    input  logic rst_n,
    input  logic btn,
    output logic press
);
`ifdef DEBOUNCE_EN
    localparam bit DEB_ON = 1'b1;
`else
    localparam bit DEB_ON = 1'b0;
`endif
    logic [SYNC_STAGES-1:0] sync;
    logic                   level;
    logic                   level_q;
    // Shift the asynchronous button through the synchroniser chain
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) sync <= '0;
        else        sync <= {sync[SYNC_STAGES-2:0], btn};
    end
    if (DEB_ON && DEB_CYCLES > 0) begin : g_deb
        localparam int DW = $clog2(DEB_CYCLES + 1);
        logic [DW-1:0] deb_cnt;
        logic          deb_level;
        // Adopt a new level only after it has differed from the current one for DEB_CYCLES cycles in a row
        always_ff @(posedge clk or negedge rst_n) begin
            if (!rst_n) begin
                deb_level <= 1'b0;
                deb_cnt   <= '0;
            end else if (sync[SYNC_STAGES-1] == deb_level) begin
                deb_cnt   <= '0;
            end else if (deb_cnt == DW'(DEB_CYCLES - 1)) begin
                deb_level <= sync[SYNC_STAGES-1];
                deb_cnt   <= '0;
            end else begin
                deb_cnt   <= deb_cnt + 1'b1;
            end
        end
        assign level = deb_level;
    end else begin : g_raw
        assign level = sync[SYNC_STAGES-1];
    end
    // Register the rising edge of the conditioned level so a held button yields one pulse
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            level_q <= 1'b0;
            press   <= 1'b0;
        end else begin
            level_q <= level;
            press   <= level & ~level_q;
        end
    end
endmodule

// File: rtl/digital_timer_ctrl.sv
// digital_timer_ctrl: run/pause/clear sequencer and tick prescaler for a 3-digit BCD counter; define DEBOUNCE_EN to debounce the buttons
module digital_timer_ctrl
    import digital_timer_pkg::*;
#(
    parameter int          TICK_DIV    = DEF_TICK_DIV,
    parameter logic [11:0] LIMIT_BCD   = DEF_LIMIT_BCD,
    parameter int          SYNC_STAGES = 2,
    parameter int          DEB_CYCLES  = 1_000_000
) (
    input  logic        clk_50MHz,
    input  logic        reset,
    input  logic        btn_start,
    input  logic        btn_clear,
    input  logic [11:0] cnt_bcd,
    output logic        cnt_en,
    output logic        cnt_clr,
    output logic        running,
    output logic        paused,
    output logic        done
);
    localparam int PW = $clog2(TICK_DIV);
    state_t        state, nxt;
    logic [PW-1:0] presc, presc_nxt;
    logic          start_p, clear_p, at_limit, wrap, en_nxt, clr_nxt, counting;
    timer_btn_cond #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_start (
        .clk(clk_50MHz), .rst_n(reset), .btn(btn_start), .press(start_p)
    );
    timer_btn_cond #(.SYNC_STAGES(SYNC_STAGES), .DEB_CYCLES(DEB_CYCLES)) u_clear (
        .clk(clk_50MHz), .rst_n(reset), .btn(btn_clear), .press(clear_p)
    );
    assign at_limit = cnt_bcd == LIMIT_BCD;
    assign wrap     = presc == PW'(TICK_DIV - 1);
    assign counting = state == RUN && !at_limit;
    // Next state and strobes; limit beats clear, clear beats start
    always_comb begin
        clr_nxt   = clear_p && !(state == RUN && at_limit);
        en_nxt    = counting && !clear_p && wrap;
        presc_nxt = (clr_nxt || state == IDLE) ? '0 : counting ? (wrap ? '0 : presc + 1'b1) : presc;
        nxt       = state;
        case (state)
            IDLE:    nxt = (start_p && !clear_p) ? RUN : IDLE;
            RUN:     nxt = at_limit ? DONE : clear_p ? IDLE : start_p ? PAUSE : RUN;
            PAUSE:   nxt = clear_p ? IDLE : start_p ? RUN : PAUSE;
            default: nxt = clear_p ? IDLE : DONE;
        endcase
    end
    // State, prescaler and registered outputs
    always_ff @(posedge clk_50MHz or negedge reset) begin
        if (!reset) begin
            state   <= IDLE;
            presc   <= '0;
            cnt_en  <= 1'b0;
            cnt_clr <= 1'b0;
            running <= 1'b0;
            paused  <= 1'b0;
            done    <= 1'b0;
        end else begin
            state   <= nxt;
            presc   <= presc_nxt;
            cnt_en  <= en_nxt;
            cnt_clr <= clr_nxt;
            running <= nxt == RUN;
            paused  <= nxt == PAUSE;
            done    <= nxt == DONE;
        end
    end
endmodule
